slot_alloc_32: RTL

//  32-entry slot/tag allocator (free list held as a bitmap). Grants the lowest-numbered

---
 rtl/slot_alloc_32_pkg.sv | 15 +
 rtl/slot_alloc_32_if.sv | 26 ++
 rtl/slot_alloc_32_prim.sv | 35 +++
 rtl/slot_alloc_32.sv | 87 ++++++++
 4 files changed

// File: rtl/slot_alloc_32_pkg.sv
// Shared sizing constants and types for the 32-entry slot allocator.
package slot_alloc_32_pkg;

   localparam int NUM_SLOTS = 32;
   localparam int IDX_W     = 5;
   localparam int CNT_W     = IDX_W + 1;

   typedef logic [NUM_SLOTS-1:0] slot_vec_t;
   typedef logic [IDX_W-1:0]     slot_idx_t;
   typedef logic [CNT_W-1:0]     slot_cnt_t;

   localparam slot_vec_t ALL_FREE = '1;
   localparam slot_cnt_t FULL_CNT = slot_cnt_t'(NUM_SLOTS);

endpackage

// File: rtl/slot_alloc_32_if.sv
// Allocation/release bus between the slot consumer (master) and the allocator (slave).
// Handshake: a grant fires on a cycle where alloc_req and alloc_ready are both 1;
// alloc_idx is meaningful only while alloc_ready is 1. free_vld has no back-pressure.
interface slot_alloc_32_if;
   import slot_alloc_32_pkg::*;

   logic      flush;
   logic      alloc_req;
   logic      alloc_ready;
   slot_idx_t alloc_idx;
   logic      free_vld;
   slot_idx_t free_idx;
   slot_cnt_t free_cnt;
   slot_vec_t busy_vec;
   logic      err_double_free;

   modport master (
      output flush, alloc_req, free_vld, free_idx,
      input  alloc_ready, alloc_idx, free_cnt, busy_vec, err_double_free
   );

   modport slave (
      input  flush, alloc_req, free_vld, free_idx,
      output alloc_ready, alloc_idx, free_cnt, busy_vec, err_double_free
   );
endinterface

// File: rtl/slot_alloc_32_prim.sv
// Priority encoder (lowest set bit) and 5-to-32 one-hot decoder used by the allocator.
module one_valid_32
   import slot_alloc_32_pkg::*;
(
   input  slot_vec_t vec_i,
   output slot_idx_t idx_o,
   output logic      valid_o
);

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      idx_o = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = slot_idx_t'(i);
      end
   end

   assign valid_o = |vec_i;

endmodule

module decoder_5_32
   import slot_alloc_32_pkg::*;
(
   input  slot_idx_t idx_i,
   input  logic      en_i,
   output slot_vec_t onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/slot_alloc_32.sv
// 32-entry slot allocator: bitmap free list, lowest-free grant, release with
// double-free detection, flush to all-free.
module slot_alloc_32
   import slot_alloc_32_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   slot_alloc_32_if.slave       bus
);

   slot_vec_t free_map_q, free_map_d;
   slot_cnt_t free_cnt_q, free_cnt_d;
   logic      err_q, err_d;

   slot_idx_t lowest_idx;
   logic      any_free;
   logic      alloc_fire;
   logic      free_en;
   logic      double_free;
   logic      free_ok;
   slot_vec_t alloc_mask;
   slot_vec_t free_mask;

   one_valid_32 u_lowest (
      .vec_i   (free_map_q),
      .idx_o   (lowest_idx),
      .valid_o (any_free)
   );

   decoder_5_32 u_alloc_dec (
      .idx_i    (lowest_idx),
      .en_i     (alloc_fire),
      .onehot_o (alloc_mask)
   );

   decoder_5_32 u_free_dec (
      .idx_i    (bus.free_idx),
      .en_i     (free_en),
      .onehot_o (free_mask)
   );

   // Flush masks the grant so a request in the flush cycle never sees a handshake.
   assign bus.alloc_ready     = any_free & ~bus.flush;
   assign bus.alloc_idx       = lowest_idx;
   assign bus.free_cnt        = free_cnt_q;
   assign bus.busy_vec        = ~free_map_q;
   assign bus.err_double_free = err_q;

   assign alloc_fire  = bus.alloc_req & bus.alloc_ready;
   assign free_en     = bus.free_vld & ~bus.flush;
   // Checked against the pre-update map, so freeing the slot being granted counts as double.
   assign double_free = |(free_mask & free_map_q);
   assign free_ok     = free_en & ~double_free;

   always_comb begin
      free_map_d = free_map_q & ~alloc_mask;
      if (free_ok) free_map_d = free_map_d | free_mask;

      free_cnt_d = free_cnt_q;
      unique case ({alloc_fire, free_ok})
         2'b10:   free_cnt_d = free_cnt_q - slot_cnt_t'(1);
         2'b01:   free_cnt_d = free_cnt_q + slot_cnt_t'(1);
         default: free_cnt_d = free_cnt_q;
      endcase

      err_d = double_free;

      if (bus.flush) begin
         free_map_d = ALL_FREE;
         free_cnt_d = FULL_CNT;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         free_map_q <= ALL_FREE;
         free_cnt_q <= FULL_CNT;
         err_q      <= 1'b0;
      end else begin
         free_map_q <= free_map_d;
         free_cnt_q <= free_cnt_d;
         err_q      <= err_d;
      end
   end

endmodule
